// File: rtl/tl_pkg.sv
// rtl/tl_pkg.sv - lamp pattern, monitor state and fault code types shared by the light monitor
package tl_pkg;

  typedef enum logic [2:0] {RED, RY, GRN, YEL, DARK, ILLEGAL} lamp_pat_t;

  typedef enum logic [2:0] {IDLE, M_RED, M_RY, M_GRN, M_YEL, M_FAULT} mon_state_t;

  typedef enum logic [2:0] {
    NONE        = 3'd0,
    ILL_PATTERN = 3'd1,
    ILL_TRANS   = 3'd2,
    DWELL_SHORT = 3'd3,
    DWELL_LONG  = 3'd4,
    BLINK       = 3'd5,
    STARTUP     = 3'd6
  } fault_code_t;

  function automatic lamp_pat_t pat_decode(input logic r, input logic y, input logic g);
    lamp_pat_t p;
    case ({r, y, g})
      3'b100:  p = RED;
      3'b110:  p = RY;
      3'b001:  p = GRN;
      3'b010:  p = YEL;
      3'b000:  p = DARK;
      default: p = ILLEGAL;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/light_sequence_monitor_if.sv
// rtl/light_sequence_monitor_if.sv - lamp level bundle between sequencer, monitor and lamp drivers
interface light_sequence_monitor_if;
  logic       red_in;
  logic       yellow_in;
  logic       green_in;
  logic       red_out;
  logic       yellow_out;
  logic       green_out;
  logic       fault;
  logic [2:0] fault_code;

  modport master (
    output red_in, yellow_in, green_in,
    input  red_out, yellow_out, green_out, fault, fault_code
  );

  modport slave (
    input  red_in, yellow_in, green_in,
    output red_out, yellow_out, green_out, fault, fault_code
  );
endinterface

// File: rtl/flash_gen.sv
// rtl/flash_gen.sv - square wave, FLASH_HALF cycles high then low, starting high when enabled
module flash_gen #(
  parameter int FLASH_HALF = 4,
  parameter int CNT_W      = 11
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en_i,
  output logic wave_o
);

  logic [CNT_W-1:0] cnt_q;
  logic             phase_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni || !en_i) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
    end else if (cnt_q == CNT_W'(FLASH_HALF - 1)) begin
      cnt_q   <= '0;
      phase_q <= ~phase_q;
    end else begin
      cnt_q   <= cnt_q + 1'b1;
    end
  end

  // Combinational gate so the first enabled cycle is already high.
  assign wave_o = en_i & ~phase_q;

endmodule

// File: rtl/light_sequence_monitor.sv
// rtl/light_sequence_monitor.sv - registered lamp pass-through with sequence/dwell checking and fail-safe flash
module light_sequence_monitor
  import tl_pkg::*;
#(
  parameter int CNT_W      = 11,
  parameter int MIN_RED    = 3,
  parameter int MAX_RED    = 32,
  parameter int MIN_RY     = 3,
  parameter int MAX_RY     = 32,
  parameter int MIN_GRN    = 4,
  parameter int MAX_GRN    = 64,
  parameter int MIN_YEL    = 3,
  parameter int MAX_YEL    = 32,
  parameter int FLASH_HALF = 4
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       red_i,
  input  logic       yellow_i,
  input  logic       green_i,
  output logic       red_o,
  output logic       yellow_o,
  output logic       green_o,
  output logic       fault_o,
  output logic [2:0] fault_code_o
);

  mon_state_t       state_q;
  fault_code_t      code_q;
  logic [CNT_W-1:0] dwell_q;
  logic             dark_q;
  logic             red_q, yel_q, grn_q;

  lamp_pat_t        pat;
  lamp_pat_t        nxt_pat;
  mon_state_t       nxt_st;
  logic             stay;
  logic [CNT_W-1:0] cur_min, cur_max, dwell_inc;
  logic             dark_d;
  logic             f_pat, f_trans, f_short, f_long, f_blink, f_start;
  fault_code_t      det_code;
  logic             flash;

  assign pat       = pat_decode(red_i, yellow_i, green_i);
  assign dwell_inc = (dwell_q == '1) ? dwell_q : dwell_q + 1'b1;

  always_comb begin
    stay    = 1'b1;
    nxt_pat = RED;
    nxt_st  = M_RED;
    cur_min = '0;
    cur_max = CNT_W'(MAX_RED);
    unique case (state_q)
      IDLE:  begin stay = (pat == DARK); end
      M_RED: begin stay = (pat == RED); nxt_pat = RY;  nxt_st = M_RY;
                   cur_min = CNT_W'(MIN_RED); cur_max = CNT_W'(MAX_RED); end
      M_RY:  begin stay = (pat == RY);  nxt_pat = GRN; nxt_st = M_GRN;
                   cur_min = CNT_W'(MIN_RY);  cur_max = CNT_W'(MAX_RY);  end
      M_GRN: begin stay = (pat == GRN) || (pat == DARK); nxt_pat = YEL; nxt_st = M_YEL;
                   cur_min = CNT_W'(MIN_GRN); cur_max = CNT_W'(MAX_GRN); end
      M_YEL: begin stay = (pat == YEL); nxt_pat = RED; nxt_st = M_RED;
                   cur_min = CNT_W'(MIN_YEL); cur_max = CNT_W'(MAX_YEL); end
      default: begin stay = 1'b1; end
    endcase
  end

  // IDLE reuses the dwell counter to time the dark startup window.
  always_comb begin
    f_pat   = 1'b0;
    f_trans = 1'b0;
    f_short = 1'b0;
    f_long  = 1'b0;
    f_blink = 1'b0;
    f_start = 1'b0;
    dark_d  = (state_q == M_GRN) && (pat == DARK);
    if (state_q != M_FAULT) begin
      f_pat = (pat == ILLEGAL);
      if (stay) begin
        if (state_q == IDLE) f_start = (dwell_q >= CNT_W'(MAX_RED));
        else                 f_long  = (dwell_q >= cur_max);
        f_blink = dark_d && dark_q;
      end else if (pat == nxt_pat) begin
        f_short = (state_q != IDLE) && (dwell_q < cur_min);
      end else begin
        f_trans = 1'b1;
      end
    end
  end

  always_comb begin
    if      (f_pat)   det_code = ILL_PATTERN;
    else if (f_trans) det_code = ILL_TRANS;
    else if (f_blink) det_code = BLINK;
    else if (f_short) det_code = DWELL_SHORT;
    else if (f_long)  det_code = DWELL_LONG;
    else if (f_start) det_code = STARTUP;
    else              det_code = NONE;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      code_q  <= NONE;
      dwell_q <= '0;
      dark_q  <= 1'b0;
      red_q   <= 1'b0;
      yel_q   <= 1'b0;
      grn_q   <= 1'b0;
    end else if (state_q != M_FAULT) begin
      if (det_code != NONE) begin
        state_q <= M_FAULT;
        code_q  <= det_code;
        red_q   <= 1'b0;
        yel_q   <= 1'b0;
        grn_q   <= 1'b0;
      end else begin
        red_q  <= red_i;
        yel_q  <= yellow_i;
        grn_q  <= green_i;
        dark_q <= dark_d;
        if (stay) begin
          dwell_q <= dwell_inc;
        end else begin
          dwell_q <= CNT_W'(1);
          state_q <= nxt_st;
        end
      end
    end
  end

  flash_gen #(
    .FLASH_HALF (FLASH_HALF),
    .CNT_W      (CNT_W)
  ) u_flash (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .en_i   (fault_o),
    .wave_o (flash)
  );

  assign fault_o      = (state_q == M_FAULT);
  assign fault_code_o = code_q;
  assign red_o        = red_q;
  assign green_o      = grn_q;
  assign yellow_o     = fault_o ? flash : yel_q;

endmodule
